// File: rtl/omsp_hmac_nbit_pkg.sv
// Shared definitions for the word-wide HMAC wrapper: FSM encoding,
// core model constants and the byte-count clamp helper.
package omsp_hmac_nbit_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_INIT     = 4'd1,
        ST_IDLE     = 4'd2,
        ST_LOAD     = 4'd3,
        ST_FEED     = 4'd4,
        ST_WAIT_IN  = 4'd5,
        ST_REQ_OUT  = 4'd6,
        ST_WAIT_OUT = 4'd7,
        ST_CAPTURE  = 4'd8
    } state_t;

    // First byte returned by the core model on a squeeze; later bytes count up.
    localparam logic [7:0] SQUEEZE_BASE = 8'hA0;

    // Number of cycles the core model stays busy after accepting a strobe.
    localparam logic [1:0] CORE_BUSY_CYCLES = 2'd3;

    // A byte count of zero or one larger than the word means "whole word".
    function automatic int unsigned clampBytes(input int unsigned bytes, input int unsigned nb);
        if ((bytes == 0) || (bytes > nb)) begin
            return nb;
        end
        return bytes;
    endfunction

endpackage

// File: rtl/omsp_hmac_nbit_hmac.sv
// Byte-serial HMAC core model: takes one byte per strobe, stays busy for a
// fixed number of cycles, and answers each squeeze with an incrementing byte.
module omsp_hmac
    import omsp_hmac_nbit_pkg::*;
#(
    parameter int KEY_SIZE = 128
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_continue_i,
    input  logic              data_available_i,
    input  logic [0:KEY_SIZE-1] key_i,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              busy_o
);

    logic [1:0] busyCnt_q, busyCnt_d;
    logic [7:0] squeezeCnt_q, squeezeCnt_d;
    logic [7:0] dataOut_q, dataOut_d;

    // The model does not hash; key and absorbed bytes are intentionally discarded.
    logic unusedInputs;
    assign unusedInputs = ^{key_i, data_i};

    // Accept a strobe only when idle; a squeeze also produces the next output byte.
    always_comb begin
        busyCnt_d    = busyCnt_q;
        squeezeCnt_d = squeezeCnt_q;
        dataOut_d    = dataOut_q;
        if (busyCnt_q != 2'd0) begin
            busyCnt_d = busyCnt_q - 2'd1;
        end else if (start_continue_i) begin
            busyCnt_d = CORE_BUSY_CYCLES;
            if (!data_available_i) begin
                dataOut_d    = SQUEEZE_BASE + squeezeCnt_q;
                squeezeCnt_d = squeezeCnt_q + 8'd1;
            end
        end
    end

    // Core state registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busyCnt_q    <= 2'd0;
            squeezeCnt_q <= 8'd0;
            dataOut_q    <= 8'd0;
        end else begin
            busyCnt_q    <= busyCnt_d;
            squeezeCnt_q <= squeezeCnt_d;
            dataOut_q    <= dataOut_d;
        end
    end

    assign busy_o = (busyCnt_q != 2'd0);
    assign data_o = dataOut_q;

endmodule

// File: rtl/omsp_hmac_nbit.sv
// Word-wide front end for the byte-serial HMAC core: absorbs up to NB bytes
// of a host word MSB first, or squeezes NB core bytes into one output word.
module omsp_hmac_nbit
    import omsp_hmac_nbit_pkg::*;
#(
    parameter int KEY_SIZE   = 128,
    parameter int DATA_WIDTH = 16,
    localparam int NB = DATA_WIDTH / 8,
    localparam int CW = $clog2(NB + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_continue,
    input  logic                  data_available,
    input  logic [CW-1:0]         data_bytes,
    input  logic [0:KEY_SIZE-1]   key,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  busy
);

    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         count_q, count_d;
    logic [KW-1:0]         k_q, k_d;
    logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
    logic                  initSent_q, initSent_d;

    logic       coreStart;
    logic       coreAvail;
    logic [7:0] coreOut;
    logic       coreBusy;

    omsp_hmac #(
        .KEY_SIZE (KEY_SIZE)
    ) hmac (
        .clk_i            (clk),
        .reset_i          (reset),
        .start_continue_i (coreStart),
        .data_available_i (coreAvail),
        .key_i            (key),
        .data_i           (shift_q[DATA_WIDTH-1 -: 8]),
        .data_o           (coreOut),
        .busy_o           (coreBusy)
    );

    // Sequencer: next state, datapath updates and core strobes.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        k_d        = k_q;
        dataOut_d  = dataOut_q;
        initSent_d = initSent_q;
        coreStart  = 1'b0;
        coreAvail  = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (start_continue) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                if (!initSent_q) begin
                    coreStart  = 1'b1;
                    coreAvail  = 1'b1;
                    initSent_d = 1'b1;
                end else if (!coreBusy) begin
                    state_d = ST_LOAD;
                end
            end
            ST_IDLE: begin
                if (start_continue) begin
                    k_d     = '0;
                    state_d = data_available ? ST_LOAD : ST_REQ_OUT;
                end
            end
            ST_LOAD: begin
                shift_d    = data_in;
                count_d    = initSent_q ? CW'(1) : CW'(clampBytes(32'(data_bytes), NB));
                initSent_d = 1'b0;
                state_d    = ST_FEED;
            end
            ST_FEED: begin
                coreStart = 1'b1;
                coreAvail = 1'b1;
                state_d   = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                if (!coreBusy) begin
                    shift_d = shift_q << 8;
                    count_d = count_q - CW'(1);
                    state_d = (count_d != '0) ? ST_FEED : ST_IDLE;
                end
            end
            ST_REQ_OUT: begin
                coreStart = 1'b1;
                state_d   = ST_WAIT_OUT;
            end
            ST_WAIT_OUT: begin
                if (!coreBusy) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                for (int i = 0; i < NB; i++) begin
                    if (k_q == KW'(NB - 1 - i)) begin
                        dataOut_d[i*8 +: 8] = coreOut;
                    end
                end
                if (k_q == KW'(NB - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ST_REQ_OUT;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase
        if (reset) begin
            state_d = ST_RESET;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RESET;
            shift_q    <= '0;
            count_q    <= '0;
            k_q        <= '0;
            dataOut_q  <= '0;
            initSent_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            count_q    <= count_d;
            k_q        <= k_d;
            dataOut_q  <= dataOut_d;
            initSent_q <= initSent_d;
        end
    end

    assign busy     = (state_d != ST_RESET) && (state_d != ST_IDLE);
    assign data_out = dataOut_q;

endmodule

// File: tb/tb_omsp_hmac_nbit.sv
// Scoreboard bench for omsp_hmac_nbit at 32-, 16- and 8-bit word widths.
module tb_omsp_hmac_nbit;
    import omsp_hmac_nbit_pkg::*;

    typedef struct packed {
        logic       da;
        logic [7:0] b;
        logic       chk;
    } strobe_t;

    logic clk = 1'b0;
    logic reset;
    logic [0:127] key = 128'h000102030405060708090A0B0C0D0E0F;

    logic        sc32, da32, busy32;
    logic [2:0]  db32;
    logic [31:0] di32, out32;
    logic        sc16, da16, busy16;
    logic [1:0]  db16;
    logic [15:0] di16, out16;
    logic        sc8, da8, busy8;
    logic [0:0]  db8;
    logic [7:0]  di8, out8;

    strobe_t     strobeQ32[$];
    strobe_t     strobeQ16[$];
    strobe_t     strobeQ8[$];
    logic [63:0] wordQ32[$];
    logic [63:0] wordQ16[$];
    logic [63:0] wordQ8[$];

    int checksRun    = 0;
    int checksPassed = 0;
    int mainFails    = 0;

    logic [2:0] prevBusy  = 3'b000;
    logic [2:0] wordPend  = 3'b000;
    logic       prevReset = 1'b0;
    logic       doneReq   = 1'b0;
    logic       doneAck   = 1'b0;
    wire  [2:0] busyVec   = {busy8, busy16, busy32};

    omsp_hmac_nbit #(.KEY_SIZE(128), .DATA_WIDTH(32)) d32 (
        .clk(clk), .reset(reset), .start_continue(sc32), .data_available(da32),
        .data_bytes(db32), .key(key), .data_in(di32), .data_out(out32), .busy(busy32)
    );

    omsp_hmac_nbit #(.KEY_SIZE(128), .DATA_WIDTH(16)) d16 (
        .clk(clk), .reset(reset), .start_continue(sc16), .data_available(da16),
        .data_bytes(db16), .key(key), .data_in(di16), .data_out(out16), .busy(busy16)
    );

    omsp_hmac_nbit #(.KEY_SIZE(128), .DATA_WIDTH(8)) d8 (
        .clk(clk), .reset(reset), .start_continue(sc8), .data_available(da8),
        .data_bytes(db8), .key(key), .data_in(di8), .data_out(out8), .busy(busy8)
    );

    // Free-running clock.
    initial begin
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checksRun++;
        if (actual === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic scoreStrobe(input string name, input int sel, input logic da, input logic [7:0] b);
        strobe_t e;
        int depth;
        depth = (sel == 0) ? strobeQ32.size() : (sel == 1) ? strobeQ16.size() : strobeQ8.size();
        if (depth == 0) begin
            checksRun++;
            $display("[TB] FAIL %s: got strobe da=%0b byte=%02h, expected no strobe", name, da, b);
        end else begin
            case (sel)
                0:       e = strobeQ32.pop_front();
                1:       e = strobeQ16.pop_front();
                default: e = strobeQ8.pop_front();
            endcase
            checkOutput(name, {55'd0, da, (e.chk ? b : 8'h00)}, {55'd0, e.da, (e.chk ? e.b : 8'h00)});
        end
    endtask

    task automatic scoreWord(input string name, input int sel, input logic [63:0] actual);
        int depth;
        logic [63:0] e;
        depth = (sel == 0) ? wordQ32.size() : (sel == 1) ? wordQ16.size() : wordQ8.size();
        if (depth == 0) begin
            checksRun++;
            $display("[TB] FAIL %s: got busy fall with data_out=%0h, expected no completion", name, actual);
        end else begin
            case (sel)
                0:       e = wordQ32.pop_front();
                1:       e = wordQ16.pop_front();
                default: e = wordQ8.pop_front();
            endcase
            checkOutput(name, actual, e);
        end
    endtask

    // Monitor: scores core strobes, settled words after busy falls, reset state and leftovers.
    always @(negedge clk) begin
        if (!reset && d32.hmac.start_continue_i)
            scoreStrobe("d32 strobe", 0, d32.hmac.data_available_i, d32.hmac.data_i);
        if (!reset && d16.hmac.start_continue_i)
            scoreStrobe("d16 strobe", 1, d16.hmac.data_available_i, d16.hmac.data_i);
        if (!reset && d8.hmac.start_continue_i)
            scoreStrobe("d8 strobe", 2, d8.hmac.data_available_i, d8.hmac.data_i);
        if (wordPend[0]) scoreWord("d32 data_out", 0, 64'(out32));
        if (wordPend[1]) scoreWord("d16 data_out", 1, 64'(out16));
        if (wordPend[2]) scoreWord("d8 data_out", 2, 64'(out8));
        wordPend <= reset ? 3'b000 : (prevBusy & ~busyVec);
        prevBusy <= busyVec;
        if (reset && prevReset) begin
            checkOutput("d32 reset data_out", 64'(out32), 64'd0);
            checkOutput("d32 reset busy", 64'(busy32), 64'd0);
            checkOutput("d32 reset state", 64'(d32.state_q), 64'(ST_RESET));
            checkOutput("d16 reset data_out", 64'(out16), 64'd0);
            checkOutput("d8 reset busy", 64'(busy8), 64'd0);
        end
        prevReset <= reset;
        if (doneReq && !doneAck) begin
            checkOutput("d32 strobes outstanding", 64'(strobeQ32.size()), 64'd0);
            checkOutput("d16 strobes outstanding", 64'(strobeQ16.size()), 64'd0);
            checkOutput("d8 strobes outstanding", 64'(strobeQ8.size()), 64'd0);
            checkOutput("words outstanding", 64'(wordQ32.size() + wordQ16.size() + wordQ8.size()), 64'd0);
            doneAck <= 1'b1;
        end
    end

    function automatic void pushStrobe(input int sel, input logic da, input logic [7:0] b, input logic chk);
        strobe_t e;
        e.da  = da;
        e.b   = b;
        e.chk = chk;
        case (sel)
            0:       strobeQ32.push_back(e);
            1:       strobeQ16.push_back(e);
            default: strobeQ8.push_back(e);
        endcase
    endfunction

    // Expected absorbed bytes, given MSB first in a 32-bit literal.
    function automatic void pushBytes(input int sel, input logic [31:0] bytesMsbFirst, input int n);
        for (int i = 0; i < n; i++) begin
            pushStrobe(sel, 1'b1, bytesMsbFirst[31 - 8*i -: 8], 1'b1);
        end
    endfunction

    function automatic void pushSqueeze(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            pushStrobe(sel, 1'b0, 8'h00, 1'b0);
        end
    endfunction

    function automatic void pushWord(input int sel, input logic [63:0] w);
        case (sel)
            0:       wordQ32.push_back(w);
            1:       wordQ16.push_back(w);
            default: wordQ8.push_back(w);
        endcase
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel == 0) ? busy32 : (sel == 1) ? busy16 : busy8;
    endfunction

    task automatic setStart(input int sel, input logic value, input logic da);
        case (sel)
            0:       begin sc32 = value; da32 = da; end
            1:       begin sc16 = value; da16 = da; end
            default: begin sc8  = value; da8  = da; end
        endcase
    endtask

    task automatic applyStimulus(input int sel, input logic da, input logic [31:0] word,
                                 input logic [3:0] nbytes, input logic glitch);
        int waited;
        @(posedge clk); #1;
        case (sel)
            0:       begin di32 = word;       db32 = nbytes[2:0]; end
            1:       begin di16 = word[15:0]; db16 = nbytes[1:0]; end
            default: begin di8  = word[7:0];  db8  = nbytes[0];   end
        endcase
        setStart(sel, 1'b1, da);
        @(posedge clk); #1;
        setStart(sel, 1'b0, da);
        if (glitch) begin
            repeat (3) @(posedge clk);
            #1;
            setStart(sel, 1'b1, ~da);
            @(posedge clk); #1;
            setStart(sel, 1'b0, da);
        end
        waited = 0;
        while (busyOf(sel) && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        if (busyOf(sel)) begin
            mainFails++;
            $display("[TB] FAIL busy timeout sel=%0d: got busy=1 after %0d cycles, expected 0", sel, waited);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Directed stimulus with hand-computed expectations pushed ahead of each command.
    initial begin
        int waited;
        reset = 1'b1;
        sc32 = 0; da32 = 0; db32 = '0; di32 = '0;
        sc16 = 0; da16 = 0; db16 = '0; di16 = '0;
        sc8  = 0; da8  = 0; db8  = '0; di8  = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 32-bit: init feeds 0x00 then the MSB of data_in
        pushBytes(0, 32'h0099_0000, 2);  pushWord(0, 64'h0);
        applyStimulus(0, 1'b1, 32'h9900_0000, 4'd4, 1'b0);
        pushBytes(0, 32'h1122_3344, 4);  pushWord(0, 64'h0);
        applyStimulus(0, 1'b1, 32'h1122_3344, 4'd4, 1'b0);
        pushBytes(0, 32'hAABB_0000, 2);  pushWord(0, 64'h0);
        applyStimulus(0, 1'b1, 32'hAABB_CCDD, 4'd2, 1'b1);
        pushSqueeze(0, 4);               pushWord(0, 64'hA0A1_A2A3);
        applyStimulus(0, 1'b0, 32'h0, 4'd0, 1'b0);
        pushBytes(0, 32'h0102_0304, 4);  pushWord(0, 64'hA0A1_A2A3);
        applyStimulus(0, 1'b1, 32'h0102_0304, 4'd0, 1'b0);
        pushBytes(0, 32'hDEAD_BEEF, 4);  pushWord(0, 64'hA0A1_A2A3);
        applyStimulus(0, 1'b1, 32'hDEAD_BEEF, 4'd7, 1'b1);
        pushSqueeze(0, 4);               pushWord(0, 64'hA4A5_A6A7);
        applyStimulus(0, 1'b0, 32'h0, 4'd4, 1'b0);

        // 16-bit
        pushBytes(1, 32'h0012_0000, 2);  pushWord(1, 64'h0);
        applyStimulus(1, 1'b1, 32'h0000_1234, 4'd2, 1'b0);
        pushBytes(1, 32'hBEEF_0000, 2);  pushWord(1, 64'h0);
        applyStimulus(1, 1'b1, 32'h0000_BEEF, 4'd0, 1'b0);
        pushBytes(1, 32'hCA00_0000, 1);  pushWord(1, 64'h0);
        applyStimulus(1, 1'b1, 32'h0000_CAFE, 4'd1, 1'b0);
        pushBytes(1, 32'h5566_0000, 2);  pushWord(1, 64'h0);
        applyStimulus(1, 1'b1, 32'h0000_5566, 4'd3, 1'b0);
        pushSqueeze(1, 2);               pushWord(1, 64'hA0A1);
        applyStimulus(1, 1'b0, 32'h0, 4'd0, 1'b0);

        // 8-bit: one strobe per command
        pushBytes(2, 32'h005A_0000, 2);  pushWord(2, 64'h0);
        applyStimulus(2, 1'b1, 32'h0000_005A, 4'd1, 1'b0);
        pushBytes(2, 32'h3C00_0000, 1);  pushWord(2, 64'h0);
        applyStimulus(2, 1'b1, 32'h0000_003C, 4'd0, 1'b0);
        pushSqueeze(2, 1);               pushWord(2, 64'hA0);
        applyStimulus(2, 1'b0, 32'h0, 4'd1, 1'b0);
        pushBytes(2, 32'h7700_0000, 1);  pushWord(2, 64'hA0);
        applyStimulus(2, 1'b1, 32'h0000_0077, 4'd1, 1'b0);
        pushSqueeze(2, 1);               pushWord(2, 64'hA1);
        applyStimulus(2, 1'b0, 32'h0, 4'd1, 1'b0);

        // 32-bit: reset while waiting on the first squeeze byte
        pushSqueeze(0, 1);
        @(posedge clk); #1;
        setStart(0, 1'b1, 1'b0);
        @(posedge clk); #1;
        setStart(0, 1'b0, 1'b0);
        waited = 0;
        while (d32.state_q != ST_WAIT_OUT && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (d32.state_q != ST_WAIT_OUT) begin
            mainFails++;
            $display("[TB] FAIL reach WAIT_OUT: got state=%0d, expected %0d", d32.state_q, ST_WAIT_OUT);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // After reset the core squeeze stream restarts at 0xA0
        pushBytes(0, 32'h0042_0000, 2);  pushWord(0, 64'h0);
        applyStimulus(0, 1'b1, 32'h4200_0000, 4'd4, 1'b0);
        pushSqueeze(0, 4);               pushWord(0, 64'hA0A1_A2A3);
        applyStimulus(0, 1'b0, 32'h0, 4'd4, 1'b0);

        doneReq = 1'b1;
        waited = 0;
        while (!doneAck && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!doneAck) begin
            mainFails++;
            $display("[TB] FAIL final scoreboard drain: got no acknowledge, expected one");
        end
        $display("%0d/%0d checks passed", checksPassed, checksRun + mainFails);
        $finish;
    end

    // Hard stop in case the run wedges.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got time limit, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/omsp_hmac_nbit.md
OMSP_HMAC_NBIT -- requirements
Module: omsp_hmac_nbit

Interface
REQ-001 The block SHALL have parameter KEY_SIZE, default 128, giving the key width in bits, passed unchanged to the core.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 16, giving the host word width in bits; legal values are 8, 16, 24, 32, 40, 48, 56 and 64.
REQ-003 The block SHALL have derived constants NB = DATA_WIDTH/8 (bytes per word) and CW = clog2(NB+1) (byte-count width).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; every register changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start_continue, input, 1 bit: command strobe, sampled only in RESET and IDLE.
REQ-007 The block SHALL have port data_available, input, 1 bit: when 1 with a command, the command is absorb; when 0, it is squeeze.
REQ-008 The block SHALL have port data_bytes, input, CW bits: number of valid input bytes, 1..NB; values 0 and >NB are treated as NB.
REQ-009 The block SHALL have port key, input, [0:KEY_SIZE-1]: the HMAC key.
REQ-010 The block SHALL have port data_in, input, DATA_WIDTH bits: input word; valid bytes are the top data_bytes bytes, sent MSB byte first.
REQ-011 The block SHALL have port data_out, output, DATA_WIDTH bits, registered: the squeezed word, MSB byte first.
REQ-012 The block SHALL have port busy, output, 1 bit: 0 only when next_state is RESET or IDLE.

Function
REQ-013 The FSM SHALL have states RESET, INIT, IDLE, LOAD, FEED, WAIT_IN, REQ_OUT, WAIT_OUT and CAPTURE.
REQ-014 RESET SHALL move to INIT when start_continue=1; INIT SHALL pulse core start_continue and data_available for 1 cycle, then hold until core busy=0, then go to LOAD with a 1-byte count.
REQ-015 In IDLE with start_continue=1, the FSM SHALL go to LOAD if data_available=1, else to REQ_OUT; with start_continue=0 it SHALL stay in IDLE.
REQ-016 LOAD SHALL latch data_in into a shift register and latch the byte count (1 for INIT, else the clamped data_bytes); this takes 1 cycle.
REQ-017 FEED SHALL present shift[DATA_WIDTH-1:DATA_WIDTH-8] to the core with start_continue=1 and data_available=1 for exactly 1 cycle, then go to WAIT_IN.
REQ-018 WAIT_IN SHALL hold while core busy=1; on busy=0 it SHALL shift left by 8 and decrement the count, then go to FEED if the count is nonzero, else to IDLE.
REQ-019 REQ_OUT SHALL assert core start_continue=1 with data_available=0 for 1 cycle; WAIT_OUT SHALL hold until core busy=0; CAPTURE SHALL load the core byte into data_out at byte index k (k=0 is the MSB).
REQ-020 After CAPTURE, the FSM SHALL go to REQ_OUT if k<NB-1, else to IDLE; a squeeze always fetches NB bytes.
REQ-021 Bytes of data_out not yet captured SHALL keep their previous values; the full word is valid when busy falls.
REQ-022 While busy=1, start_continue and data_in SHALL be ignored.
REQ-023 The block SHALL generate no X on its outputs for any input sequence.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL set state=RESET, data_out=0, shift register=0, count=0 and k=0, regardless of the current state.
REQ-025 During and after reset, busy SHALL be 0 until a command is accepted.
REQ-026 Reset mid-transfer SHALL abort the transfer; the core is reset by the same signal.

Structure
REQ-027 A shared package SHALL hold the state encoding (4 bits) and the clamp function for data_bytes.
REQ-028 The block SHALL instantiate exactly one sub-module, omsp_hmac #(KEY_SIZE) hmac, with the byte fed directly from the shift-register MSB.

Verification
REQ-029 A stub core SHALL be used: busy=1 for 3 cycles after each strobe; on squeeze it returns the byte counter 0xA0, 0xA1, ….
REQ-030 Scenario: DATA_WIDTH=32, init, then absorb data_in=0x11223344 with data_bytes=4 -> the core receives 0x11, 0x22, 0x33, 0x44 in order, each strobe lasting exactly 1 cycle.
REQ-031 Scenario: DATA_WIDTH=32, absorb with data_bytes=2 and data_in=0xAABBCCDD -> exactly 2 strobes (0xAA, 0xBB), then busy falls.
REQ-032 Scenario: DATA_WIDTH=32, squeeze -> data_out=0xA0A1A2A3 when busy falls, with 4 core strobes, all with data_available=0.
REQ-033 Scenario: DATA_WIDTH=16, data_bytes=0 -> the block behaves as data_bytes=2; DATA_WIDTH=8 yields 1 strobe per command.
REQ-034 Scenario: reset asserted in WAIT_OUT -> next cycle data_out=0, busy=0, state=RESET; a start_continue pulse during busy is ignored.
